// File: rtl/md_if.sv
// md_if: issue/result bundle between the pipeline and the multiply/divide unit
interface md_if #(parameter int WIDTH = 32);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             req;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, op, a, b, req, input busy, done, hi, lo);
  modport slave (input start, op, a, b, req, output busy, done, hi, lo);
endinterface

// File: rtl/md_unit_param.sv
// md_unit_param: HI/LO owner executing mult/div/madd/msub and HI/LO moves with fixed latencies
module md_unit_param #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic clk,
  input logic reset,
  md_if.slave bus
);
  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MUL_L = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_L = CW'(DIV_CYCLES);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [2*WIDTH-1:0] sh_q;
  logic               busy_q, done_q;
  logic               issue, multi, is_div, sg, an, bn, bz;
  logic [CW-1:0]      lat;
  logic [2*WIDTH-1:0] sa, sb, ua, ub, sp, up, acc, res;
  logic [WIDTH-1:0]   ma, mb, mbs, q, r, dq, dr;
  assign issue  = bus.start & ~bus.req & ~busy_q & (bus.op >= 4'd1) & (bus.op <= 4'd10);
  assign multi  = (bus.op != 4'd5) & (bus.op != 4'd6);
  assign is_div = (bus.op == 4'd3) | (bus.op == 4'd4);
  assign lat    = is_div ? DIV_L : MUL_L;
  assign sa  = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
  assign sb  = {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
  assign ua  = {{WIDTH{1'b0}}, bus.a};
  assign ub  = {{WIDTH{1'b0}}, bus.b};
  assign sp  = sa * sb;
  assign up  = ua * ub;
  assign acc = {hi_q, lo_q};
  // Signed divide runs on magnitudes; the most-negative / -1 case falls out as quotient = a, remainder 0.
  assign sg  = bus.op == 4'd3;
  assign an  = sg & bus.a[WIDTH-1];
  assign bn  = sg & bus.b[WIDTH-1];
  assign bz  = bus.b == '0;
  assign ma  = an ? -bus.a : bus.a;
  assign mb  = bn ? -bus.b : bus.b;
  assign mbs = bz ? WIDTH'(1) : mb;
  assign q   = ma / mbs;
  assign r   = ma % mbs;
  assign dq  = bz ? '1 : ((an ^ bn) ? -q : q);
  assign dr  = bz ? bus.a : (an ? -r : r);
  assign res = (bus.op == 4'd1)  ? sp :
               (bus.op == 4'd2)  ? up :
               (bus.op == 4'd7)  ? acc + sp :
               (bus.op == 4'd8)  ? acc + up :
               (bus.op == 4'd9)  ? acc - sp :
               (bus.op == 4'd10) ? acc - up : {dr, dq};
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  // Issue captures the result into a shadow, then the countdown commits it to HI/LO with a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sh_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (issue) begin
          if (bus.op == 4'd5) hi_q <= bus.a;
          else if (bus.op == 4'd6) lo_q <= bus.a;
          if (multi) begin
            sh_q    <= res;
            cnt_q   <= lat;
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: if (cnt_q == CW'(1)) begin
          {hi_q, lo_q} <= sh_q;
          cnt_q        <= '0;
          busy_q       <= 1'b0;
          done_q       <= 1'b1;
          state_q      <= IDLE;
        end else cnt_q <= cnt_q - CW'(1);
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_md_unit_param.sv
// tb_md_unit_param: directed vector table plus hand sequences for req, restart, reset and a 16-bit build
module tb_md_unit_param;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  md_if #(.WIDTH(32)) m();
  md_if #(.WIDTH(16)) n();
  md_unit_param #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .bus(m));
  md_unit_param #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(3)) dut16 (.clk(clk), .reset(reset), .bus(n));
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] eh;
    logic [31:0] el;
    int          rq;
    int          st;
  } vec_t;
  vec_t tv[15];
  int errs = 0;
  int checks = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic run(input vec_t v, input string nm);
    logic [31:0] ph, pl;
    bit chg;
    int cyc;
    @(negedge clk);
    ph = m.hi; pl = m.lo;
    m.start = 1'b1; m.op = v.op; m.a = v.a; m.b = v.b; m.req = 1'b0;
    @(negedge clk);
    m.start = 1'b0; m.op = 4'd0;
    cyc = 1; chg = 1'b0;
    while (m.busy && cyc < 60) begin
      chg |= (m.hi !== ph) || (m.lo !== pl) || m.done;
      m.req = (cyc == v.rq);
      m.start = (cyc == v.st);
      m.op = 4'd1; m.a = 32'd7; m.b = 32'd7;
      @(negedge clk);
      cyc++;
    end
    m.req = 1'b0; m.start = 1'b0; m.op = 4'd0;
    chk({nm, " busy_cycles"}, 64'(cyc - 1), 64'(v.lat));
    chk({nm, " hold_while_busy"}, 64'(chg), 64'd0);
    chk({nm, " done"}, 64'(m.done), 64'(v.lat != 0));
    chk({nm, " hi"}, 64'(m.hi), 64'(v.eh));
    chk({nm, " lo"}, 64'(m.lo), 64'(v.el));
    @(negedge clk);
    chk({nm, " done_pulse_end"}, 64'(m.done), 64'd0);
    chk({nm, " idle_after"}, 64'(m.busy), 64'd0);
  endtask
  task automatic run16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input int lat, input logic [15:0] eh, input logic [15:0] el, input string nm);
    int cyc;
    @(negedge clk);
    n.start = 1'b1; n.op = op; n.a = a; n.b = b; n.req = 1'b0;
    @(negedge clk);
    n.start = 1'b0; n.op = 4'd0;
    cyc = 1;
    while (n.busy && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, " busy_cycles"}, 64'(cyc - 1), 64'(lat));
    chk({nm, " done"}, 64'(n.done), 64'd1);
    chk({nm, " hi"}, 64'(n.hi), 64'(eh));
    chk({nm, " lo"}, 64'(n.lo), 64'(el));
  endtask
  initial begin
    bit bad;
    vec_t v;
    m.start = 1'b0; m.op = 4'd0; m.a = '0; m.b = '0; m.req = 1'b0;
    n.start = 1'b0; n.op = 4'd0; n.a = '0; n.b = '0; n.req = 1'b0;
    tv[0]  = '{4'd1,  32'hFFFFFFFF, 32'd2,          5,  32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0};
    tv[1]  = '{4'd2,  32'hFFFFFFFF, 32'd2,          5,  32'h00000001, 32'hFFFFFFFE, 0, 0};
    tv[2]  = '{4'd4,  32'd7,        32'd2,          10, 32'd1,        32'd3,        0, 0};
    tv[3]  = '{4'd3,  32'hFFFFFFF9, 32'd2,          10, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0};
    tv[4]  = '{4'd3,  32'd5,        32'd0,          10, 32'd5,        32'hFFFFFFFF, 0, 0};
    tv[5]  = '{4'd3,  32'h80000000, 32'hFFFFFFFF,   10, 32'd0,        32'h80000000, 0, 0};
    tv[6]  = '{4'd4,  32'd5,        32'd0,          10, 32'd5,        32'hFFFFFFFF, 0, 0};
    tv[7]  = '{4'd5,  32'd0,        32'd0,          0,  32'd0,        32'hFFFFFFFF, 0, 0};
    tv[8]  = '{4'd6,  32'hFFFFFFFF, 32'd0,          0,  32'd0,        32'hFFFFFFFF, 0, 0};
    tv[9]  = '{4'd7,  32'd1,        32'd1,          5,  32'd1,        32'd0,        0, 0};
    tv[10] = '{4'd10, 32'd1,        32'd1,          5,  32'd0,        32'hFFFFFFFF, 0, 0};
    tv[11] = '{4'd9,  32'd2,        32'hFFFFFFFD,   5,  32'd1,        32'd5,        0, 0};
    tv[12] = '{4'd8,  32'hFFFFFFFF, 32'hFFFFFFFF,   5,  32'hFFFFFFFF, 32'd6,        0, 0};
    tv[13] = '{4'd3,  32'd7,        32'hFFFFFFFE,   10, 32'd1,        32'hFFFFFFFD, 0, 0};
    tv[14] = '{4'd1,  32'd5,        32'd5,          5,  32'd0,        32'd25,       0, 0};
    repeat (2) @(negedge clk);
    chk("reset hi", 64'(m.hi), 64'd0);
    chk("reset lo", 64'(m.lo), 64'd0);
    chk("reset busy", 64'(m.busy), 64'd0);
    chk("reset done", 64'(m.done), 64'd0);
    reset = 1'b1;
    for (int i = 0; i < 15; i++) run(tv[i], $sformatf("vec%0d", i));
    @(negedge clk);
    m.start = 1'b1; m.req = 1'b1; m.op = 4'd1; m.a = 32'd3; m.b = 32'd3;
    @(negedge clk);
    m.start = 1'b0; m.req = 1'b0; m.op = 4'd0;
    bad = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bad |= m.busy || m.done || (m.lo !== 32'd25) || (m.hi !== 32'd0);
      @(negedge clk);
    end
    chk("req_at_issue suppressed", 64'(bad), 64'd0);
    v = '{4'd1, 32'd3, 32'd3, 5, 32'd0, 32'd9, 2, 0};
    run(v, "req_mid_op");
    v = '{4'd1, 32'd4, 32'd4, 5, 32'd0, 32'd16, 0, 3};
    run(v, "start_while_busy");
    @(negedge clk);
    m.start = 1'b1; m.op = 4'd3; m.a = 32'd100; m.b = 32'd7;
    @(negedge clk);
    m.start = 1'b0; m.op = 4'd0;
    repeat (3) @(negedge clk);
    chk("div busy before reset", 64'(m.busy), 64'd1);
    reset = 1'b0;
    #1;
    chk("async reset busy", 64'(m.busy), 64'd0);
    chk("async reset hi", 64'(m.hi), 64'd0);
    chk("async reset lo", 64'(m.lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 14; i++) begin
      bad |= m.done || m.busy || (m.lo !== 32'd0);
      @(negedge clk);
    end
    chk("no done after reset", 64'(bad), 64'd0);
    run16(4'd1, 16'hFFFF, 16'hFFFF, 1, 16'h0000, 16'h0001, "w16 mult");
    run16(4'd2, 16'hFFFF, 16'hFFFF, 1, 16'hFFFE, 16'h0001, "w16 multu");
    run16(4'd3, 16'h8000, 16'hFFFF, 3, 16'h0000, 16'h8000, "w16 div ovf");
    run16(4'd4, 16'd9,    16'd4,    3, 16'd1,    16'd2,    "w16 divu");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/md_unit_param.md
# md_unit_param

Parametrised multiply/divide unit for the E stage of the five-stage pipeline. It owns the HI/LO architectural registers and executes signed and unsigned multiply, divide and multiply-accumulate operations with configurable latencies. It also executes HI/LO moves and exposes a start/busy handshake to the stall logic. Interrupt and exception requests cancel an operation only on its issue cycle.

## Interface
- WIDTH, 32: operand and HI/LO width in bits (≥ 8).
- MUL_CYCLES, 5: busy cycles for mult/multu/madd/maddu/msub/msubu (≥ 1).
- DIV_CYCLES, 10: busy cycles for div/divu (≥ 1).

- clk  input  1  pipeline clock, all state on rising edge.
- reset  input  1  asynchronous, active-low; clears all state.
- start  input  1  issue strobe; valid with op, a, b in the same cycle.
- op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu, 11–15 none.
- a  input  WIDTH  forwarded rs value.
- b  input  WIDTH  forwarded rt value.
- req  input  1  CP0 exception/interrupt request; suppresses issue.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse when HI/LO receive a multi-cycle result.
- hi  output  WIDTH  HI register, read directly for mfhi.
- lo  output  WIDTH  LO register, read directly for mflo.

## Operation
- Issue condition: start & !req & !busy & op in 1..10. Otherwise the cycle is ignored and no state changes.
- mthi/mtlo: the issue edge writes hi (or lo) with a. busy stays 0 and done is not pulsed.
- Multi-cycle ops: at the issue edge, the full result is computed from a and b and captured into shadow registers. The counter is loaded with the latency and busy is set.
- FSM states:
  - IDLE → BUSY on a multi-cycle issue.
  - BUSY counts down. When the count reaches 1, the next edge commits shadow→hi/lo, clears busy, sets done, and returns to IDLE.
- mult/multu: {hi,lo} = signed/unsigned 2·WIDTH product of a and b.
- madd/maddu/msub/msubu: {hi,lo} = {hi,lo} ± product, modulo 2^(2·WIDTH). The accumulator operand is the hi/lo value at the issue edge.
- div/divu: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
- Divide by zero: lo = all ones, hi = a. Applies to both signedness modes.
- Signed overflow (a = most-negative, b = −1): lo = a, hi = 0.
- req while busy: no effect, the in-flight op completes. It was issued before the exception point and is architecturally committed.
- start while busy: ignored. Upstream stall logic guarantees md/mf/mt instructions are held in D while start | busy.
- Counter width: $clog2(max(MUL_CYCLES, DIV_CYCLES) + 1).

## Timing
- Reset (reset = 0, asynchronous): hi = 0, lo = 0, busy = 0, done = 0, counter = 0, state IDLE. Takes effect immediately, including mid-operation. The in-flight result is discarded.
- Issue in cycle 0:
  - busy = 1 in cycles 1..L, where L = MUL_CYCLES or DIV_CYCLES.
  - hi/lo hold their old values through cycle L.
  - New hi/lo are visible and done = 1 in cycle L+1, with busy = 0.
- A new op may issue in cycle L+1.
- mthi/mtlo issued in cycle 0: new value visible in cycle 1.
- done is high for exactly one cycle per multi-cycle op.

## Test plan
- mult, a = 0xFFFFFFFF, b = 2 → busy in cycles 1–5; in cycle 6: hi = 0xFFFFFFFF, lo = 0xFFFFFFFE, done = 1.
- multu with the same operands → hi = 0x00000001, lo = 0xFFFFFFFE.
- divu 7/2 → after 10 busy cycles: lo = 3, hi = 1.
- div −7/2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- div 5/0 → lo = 0xFFFFFFFF, hi = 5.
- div 0x80000000/0xFFFFFFFF → lo = 0x80000000, hi = 0.
- mthi 0, then mtlo 0xFFFFFFFF, then madd 1×1 → hi = 1, lo = 0.
- Then msubu 1×1 → hi = 0, lo = 0xFFFFFFFF.
- start with req = 1 (mult 3×3) → busy stays 0, hi/lo unchanged, no done.
- req pulsed in cycle 2 of a mult → completes normally with product 9.
- Second start in cycle 3 of a busy op → ignored.
- reset low in cycle 4 of div → busy, hi, lo = 0 immediately, no done afterwards.
- Rerun WIDTH = 16, MUL_CYCLES = 1 → mult 0xFFFF×0xFFFF gives hi = 0x0000, lo = 0x0001, one busy cycle.
